// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle adder: computes a + b + cin over CHUNKS = WIDTH/DIGIT cycles.
//   Each cycle adds one DIGIT-wide chunk, LSB chunk first, through a DIGIT-bit adder
//   with a registered carry. Valid/ready handshake on both input and output sides.
//   Optional feature macro: SERIAL_CHUNK_ADDER_SUB_EN adds a `sub` input; sub=1 computes
//   a + ~b + cin (a - b when cin=1).
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in idle)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in
//   sub        in   1      subtract select (SERIAL_CHUNK_ADDER_SUB_EN builds only)
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of MSB (for subtract: 1 = no borrow)
//   ovf        out  1      signed two's complement overflow
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned DIGIT_SAFE = (DIGIT == 0) ? 1 : DIGIT;
  localparam int unsigned CHUNKS     = WIDTH / DIGIT_SAFE;
  localparam int unsigned CNT_W      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if ((DIGIT == 0) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_bad_digit
    $error("serial_chunk_adder: WIDTH (%0d) must be a non-zero multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT-1:0] a_lo, b_lo;
  logic [DIGIT:0]   chunk_sum;
  logic [WIDTH-1:0] res_shift;
  logic             chunk_ovf;
  logic             b_inv;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign b_inv = sub;
`else
  assign b_inv = 1'b0;
`endif

  // Operands shift right one chunk per cycle, so the active chunk is always the low DIGIT bits.
  assign a_lo      = a_q[DIGIT-1:0];
  assign b_lo      = b_q[DIGIT-1:0];
  assign chunk_sum = {1'b0, a_lo} + {1'b0, b_lo} + {{DIGIT{1'b0}}, carry_q};

  // Same-sign operands producing a different-sign result; equivalent to
  // carry-into-MSB xor carry-out-of-MSB on the final chunk.
  assign chunk_ovf = (a_lo[DIGIT-1] == b_lo[DIGIT-1]) && (chunk_sum[DIGIT-1] != a_lo[DIGIT-1]);

  // Result chunks enter at the top and shift down; after CHUNKS cycles chunk 0 sits at the LSB.
  if (CHUNKS > 1) begin : g_multi
    assign res_shift = {chunk_sum[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign res_shift = chunk_sum[DIGIT-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_inv ? ~b : b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chunk_sum[DIGIT];
        res_d   = res_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // sum is only updated once the full result is assembled.
          sum_d   = res_shift;
          cout_d  = chunk_sum[DIGIT];
          ovf_d   = chunk_ovf;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed testbench for serial_chunk_adder: a WIDTH=16/DIGIT=4 instance and a
// WIDTH=16/DIGIT=16 single-chunk instance. Subtract vectors run when
// SERIAL_CHUNK_ADDER_SUB_EN is defined.
module tb_serial_chunk_adder;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, cout, ovf;
  logic        sub;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [15:0] d_a, d_b, d_sum;
  logic        d_cin, d_cout, d_ovf;

  int checks = 0;
  int errors = 0;
  int lat;

  serial_chunk_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  serial_chunk_adder #(.WIDTH(16), .DIGIT(16)) dut_one (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .a         (d_a),
    .b         (d_b),
    .cin       (d_cin),
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .sum       (d_sum),
    .cout      (d_cout),
    .ovf       (d_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand set, wait for acceptance, then count edges until out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        output int tlat);
    a        = ta;
    b        = tb_v;
    cin      = tc;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tlat     = 0;
    while (out_valid !== 1'b1 && tlat < 20) begin
      @(posedge clk); #1;
      tlat++;
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovalid_low"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_iready_high"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    cin         = 1'b0;
    sub         = 1'b0;
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    d_a         = '0;
    d_b         = '0;
    d_cin       = 1'b0;

    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full carry ripple through all chunks.
    run_op(16'hFFFF, 16'h0001, 1'b0, lat);
    check("ripple_latency", lat, 32'd4);
    check("ripple_sum", {16'd0, sum}, 32'h0000);
    check("ripple_cout", {31'd0, cout}, 32'd1);
    check("ripple_ovf", {31'd0, ovf}, 32'd0);
    drain("ripple");

    // Signed overflow.
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    check("ovf_latency", lat, 32'd4);
    check("ovf_sum", {16'd0, sum}, 32'h8000);
    check("ovf_cout", {31'd0, cout}, 32'd0);
    check("ovf_ovf", {31'd0, ovf}, 32'd1);
    drain("ovf");

    // Carry in.
    run_op(16'h1234, 16'h0FFF, 1'b1, lat);
    check("cin_sum", {16'd0, sum}, 32'h2234);
    check("cin_cout", {31'd0, cout}, 32'd0);
    check("cin_ovf", {31'd0, ovf}, 32'd0);
    drain("cin");

    // Backpressure, plus input changes during RUN that must be ignored.
    a        = 16'h00FF;
    b        = 16'h0F01;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a   = 16'hAAAA;
    b   = 16'h5555;
    cin = 1'b1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_sum", {16'd0, sum}, 32'h1000);
      check("bp_cout_ovf", {30'd0, cout, ovf}, 32'd0);
      check("bp_ovalid", {31'd0, out_valid}, 32'd1);
      check("bp_iready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp_sum_hold", {16'd0, sum}, 32'h1000);

    // Reset after the second chunk aborts the operation.
    a        = 16'hFFFF;
    b        = 16'hFFFF;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    check("abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0003, 16'h0004, 1'b0, lat);
    check("post_abort_latency", lat, 32'd4);
    check("post_abort_sum", {16'd0, sum}, 32'h0007);
    check("post_abort_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    drain("post_abort");

    // Single-chunk instance.
    d_a        = 16'h8000;
    d_b        = 16'h8000;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 0;
    while (d_out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("one_latency", lat, 32'd1);
    check("one_sum", {16'd0, d_sum}, 32'h0000);
    check("one_cout", {31'd0, d_cout}, 32'd1);
    check("one_ovf", {31'd0, d_ovf}, 32'd1);
    @(posedge clk); #1;
    check("one_iready", {31'd0, d_in_ready}, 32'd1);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    sub = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b1, lat);
    check("sub_latency", lat, 32'd4);
    check("sub_sum", {16'd0, sum}, 32'hFFFE);
    check("sub_cout", {31'd0, cout}, 32'd0);
    check("sub_ovf", {31'd0, ovf}, 32'd0);
    drain("sub");
    run_op(16'h8000, 16'h0001, 1'b1, lat);
    check("subovf_sum", {16'd0, sum}, 32'h7FFF);
    check("subovf_cout", {31'd0, cout}, 32'd1);
    check("subovf_ovf", {31'd0, ovf}, 32'd1);
    drain("subovf");
    sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
